// File: rtl/hdmi_link_pkg.sv
// Shared types and constants for the HDMI link sequencer.
// Holds the state encoding and the cycles-from-microseconds helper.
package hdmi_link_pkg;

  localparam int STATE_W = 3;
  localparam int CLOCK_FREQUENCY = 200_000_000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_GT_WAIT    = 3'd2,
    ST_CONFIG     = 3'd3,
    ST_RUN        = 3'd4,
    ST_RETRY_WAIT = 3'd5,
    ST_FAULT      = 3'd6,
    ST_DRAIN      = 3'd7
  } link_state_e;

  function automatic int cycles_from_us(int us);
    return (CLOCK_FREQUENCY / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/hdmi_hpd_conditioner.sv
// Hot-plug detect synchroniser with asymmetric rise/fall debounce.
// A single counter tracks consecutive samples that disagree with the output.
module hdmi_hpd_conditioner #(
  parameter int RISE_CYCLES = 2_000_000,
  parameter int FALL_CYCLES = 2_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hpd_i,
  output logic hpd_stable_o
);

  localparam int MAXC = (RISE_CYCLES > FALL_CYCLES) ? RISE_CYCLES : FALL_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RISE_LAST = CW'(RISE_CYCLES - 1);
  localparam logic [CW-1:0] FALL_LAST = CW'(FALL_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] limit;

  // The sample that lands with the count at limit is the Nth in a row.
  always_comb begin
    limit    = stable_q ? FALL_LAST : RISE_LAST;
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q >= limit) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= hpd_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hpd_stable_o = stable_q;

endmodule

// File: rtl/hdmi_link_sequencer.sv
// Per-port HDMI link bring-up: HPD settle, GT wait, redriver config, run.
// Tears down on HPD loss, GT loss or exhausted configuration retries.
module hdmi_link_sequencer
  import hdmi_link_pkg::*;
#(
  parameter int HPD_DEBOUNCE_CYCLES = cycles_from_us(10_000),
  parameter int HPD_LOSS_CYCLES     = cycles_from_us(10),
  parameter int SETTLE_CYCLES       = cycles_from_us(100_000),
  parameter int RETRY_WAIT_CYCLES   = cycles_from_us(1_000),
  parameter int RETRY_LIMIT         = 3
) (
  input  logic         system_clock,
  input  logic         system_reset_n,
  input  logic         hpd,
  input  logic         gt_tx_ready,
  output logic         cfg_req,
  input  logic         cfg_done,
  input  logic         cfg_error,
  output logic         run,
  output logic         hpd_stable,
  output logic         fault,
  output logic [2:0]   state,
  output logic [3:0]   attempt
);

  localparam int MAXT = (SETTLE_CYCLES > RETRY_WAIT_CYCLES) ? SETTLE_CYCLES : RETRY_WAIT_CYCLES;
  localparam int TW = $clog2(MAXT + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] RETRY_LAST  = TW'(RETRY_WAIT_CYCLES - 1);
  localparam logic [3:0]    LIMIT       = 4'(RETRY_LIMIT);

  link_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    attempt_q, attempt_d;

  hdmi_hpd_conditioner #(
    .RISE_CYCLES (HPD_DEBOUNCE_CYCLES),
    .FALL_CYCLES (HPD_LOSS_CYCLES)
  ) u_hpd (
    .clk_i        (system_clock),
    .rst_ni       (system_reset_n),
    .hpd_i        (hpd),
    .hpd_stable_o (hpd_stable)
  );

  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      attempt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      attempt_q <= attempt_d;
    end
  end

  // HPD loss is tested first everywhere so it outranks GT loss and cfg_done.
  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hpd_stable) begin
          state_d   = ST_SETTLE;
          attempt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!hpd_stable)             state_d = ST_IDLE;
        else if (timer_q >= SETTLE_LAST) state_d = ST_GT_WAIT;
      end
      ST_GT_WAIT: begin
        if (!hpd_stable) begin
          state_d = ST_IDLE;
        end else if (gt_tx_ready) begin
          state_d   = ST_CONFIG;
          attempt_d = (attempt_q == 4'hF) ? attempt_q : attempt_q + 4'd1;
        end
      end
      ST_CONFIG: begin
        if (!hpd_stable)         state_d = cfg_done ? ST_IDLE : ST_DRAIN;
        else if (cfg_done) begin
          if (!cfg_error)             state_d = ST_RUN;
          else if (attempt_q < LIMIT) state_d = ST_RETRY_WAIT;
          else                        state_d = ST_FAULT;
        end
      end
      ST_RUN: begin
        if (!hpd_stable)       state_d = ST_IDLE;
        else if (!gt_tx_ready) state_d = ST_GT_WAIT;
      end
      ST_RETRY_WAIT: begin
        if (!hpd_stable)                state_d = ST_IDLE;
        else if (timer_q >= RETRY_LAST) state_d = ST_GT_WAIT;
      end
      ST_FAULT: begin
        if (!hpd_stable) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (cfg_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q == '1)  timer_d = timer_q;
    else                     timer_d = timer_q + 1'b1;
  end

  always_comb begin
    cfg_req = (state_q == ST_CONFIG) || (state_q == ST_DRAIN);
    run     = (state_q == ST_RUN);
    fault   = (state_q == ST_FAULT);
    state   = state_q;
    attempt = attempt_q;
  end

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// Randomised and directed bench for hdmi_link_sequencer against a
// dwell-time/run-length reference model of the link behaviour.
module tb_hdmi_link_sequencer;

  localparam int DEB    = 8;
  localparam int LOSS   = 4;
  localparam int SETTLE = 16;
  localparam int RETRY  = 10;
  localparam int LIMIT  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hpd = 1'b0;
  logic       gt = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cfg_error = 1'b0;
  logic       cfg_req, run, hpd_stable, fault;
  logic [2:0] state;
  logic [3:0] attempt;

  hdmi_link_sequencer #(
    .HPD_DEBOUNCE_CYCLES (DEB),
    .HPD_LOSS_CYCLES     (LOSS),
    .SETTLE_CYCLES       (SETTLE),
    .RETRY_WAIT_CYCLES   (RETRY),
    .RETRY_LIMIT         (LIMIT)
  ) dut (
    .system_clock   (clk),
    .system_reset_n (rst_n),
    .hpd            (hpd),
    .gt_tx_ready    (gt),
    .cfg_req        (cfg_req),
    .cfg_done       (cfg_done),
    .cfg_error      (cfg_error),
    .run            (run),
    .hpd_stable     (hpd_stable),
    .fault          (fault),
    .state          (state),
    .attempt        (attempt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: hpd history, run lengths and dwell times.
  bit m_d1, m_d2, m_prev, m_stab;
  int m_streak, m_st, m_dwell, m_att;

  // Config engine stand-in.
  int busy = 0, left = 0, resp_dly = 3;
  bit resp_err = 1'b0, rand_err = 1'b0, stray = 1'b0;

  task automatic model_step();
    bit old;
    bit hs;
    int nst;
    if (!rst_n) begin
      m_d1 = 0; m_d2 = 0; m_prev = 0; m_stab = 0;
      m_streak = 0; m_st = 0; m_dwell = 0; m_att = 0;
    end else begin
      old = m_stab;
      nst = m_st;
      if (m_st == 7) begin
        if (cfg_done) nst = 0;
      end else if (m_st != 0 && !old) begin
        nst = (m_st == 3 && !cfg_done) ? 7 : 0;
      end else if (m_st == 0) begin
        if (old) begin nst = 1; m_att = 0; end
      end else if (m_st == 1) begin
        if (m_dwell + 1 >= SETTLE) nst = 2;
      end else if (m_st == 2) begin
        if (gt) begin nst = 3; m_att = (m_att < 15) ? m_att + 1 : 15; end
      end else if (m_st == 3) begin
        if (cfg_done) nst = !cfg_error ? 4 : (m_att < LIMIT ? 5 : 6);
      end else if (m_st == 4) begin
        if (!gt) nst = 2;
      end else if (m_st == 5) begin
        if (m_dwell + 1 >= RETRY) nst = 2;
      end
      m_dwell = (nst == m_st) ? m_dwell + 1 : 0;
      m_st = nst;
      hs = m_d2;
      m_d2 = m_d1;
      m_d1 = hpd;
      m_streak = (hs == m_prev) ? m_streak + 1 : 1;
      m_prev = hs;
      if (!m_stab && hs && m_streak >= DEB) m_stab = 1;
      else if (m_stab && !hs && m_streak >= LOSS) m_stab = 0;
    end
  endtask

  logic [11:0] exp_v, got_v;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {m_st[2:0], (m_st == 3 || m_st == 7), (m_st == 4),
               (m_st == 6), m_stab, m_att[3:0]};
      got_v = {state, cfg_req, run, fault, hpd_stable, attempt};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model t=%0t got st=%0d req=%b run=%b flt=%b stab=%b att=%0d want st=%0d req=%b run=%b flt=%b stab=%b att=%0d",
                 $time, got_v[11:9], got_v[8], got_v[7], got_v[6], got_v[5], got_v[3:0],
                 exp_v[11:9], exp_v[8], exp_v[7], exp_v[6], exp_v[5], exp_v[3:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (!rst_n) begin
      cfg_done = 0; cfg_error = 0; busy = 0;
    end else if (cfg_done) begin
      cfg_done = 0; cfg_error = 0; busy = 0;
    end else if (busy != 0 || cfg_req) begin
      if (busy == 0) begin busy = 1; left = resp_dly; end
      left--;
      if (left <= 0) begin
        cfg_done = 1;
        cfg_error = rand_err ? 1'($urandom_range(0, 1)) : resp_err;
      end
    end else if (stray && $urandom_range(0, 15) == 0) begin
      cfg_done = 1;
      cfg_error = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pin(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    int n, cnt;
    bit seen;
    rst_n = 0;
    tick(); tick();
    chk_en = 1;
    pin("reset_state", state, 0);
    pin("reset_cfg_req", cfg_req, 0);
    pin("reset_attempt", attempt, 0);
    rst_n = 1;
    tick(); tick();

    // Happy path
    hpd = 1; gt = 1; resp_dly = 3; resp_err = 0;
    n = 0;
    while (!hpd_stable && n < 50) begin tick(); n++; end
    pin("debounce_latency", n, 10);
    pin("model_debounce", m_stab, 1);
    cnt = 0; n = 0;
    while (state != 4 && n < 100) begin
      tick(); n++;
      if (state == 1) cnt++;
    end
    pin("settle_cycles", cnt, SETTLE);
    pin("happy_state", state, 4);
    pin("happy_run", run, 1);
    pin("happy_attempt", attempt, 1);
    pin("model_happy_att", m_att, 1);

    // HPD glitch during debounce
    hpd = 0;
    n = 0;
    while (state != 0 && n < 30) begin tick(); n++; end
    repeat (3) tick();
    hpd = 1; repeat (5) tick();
    hpd = 0; tick();
    hpd = 1;
    n = 0;
    while (!hpd_stable && n < 50) begin tick(); n++; end
    pin("glitch_debounce", n, 10);
    n = 0;
    while (state != 4 && n < 100) begin tick(); n++; end
    pin("glitch_reach_run", state, 4);
    hpd = 0; repeat (3) tick();
    hpd = 1;
    seen = 0;
    repeat (10) begin tick(); if (!run) seen = 1; end
    pin("run_glitch_drop", seen, 0);

    // Retry then fault
    hpd = 0;
    n = 0;
    while (state != 0 && n < 30) begin tick(); n++; end
    resp_err = 1; hpd = 1;
    cnt = 0; n = 0;
    while (!fault && n < 200) begin
      tick(); n++;
      if (state == 5) cnt++;
    end
    pin("retry_wait_cycles", cnt, RETRY);
    pin("fault_flag", fault, 1);
    pin("fault_state", state, 6);
    pin("fault_run", run, 0);
    pin("fault_attempt", attempt, 2);
    pin("model_fault_st", m_st, 6);
    hpd = 0;
    n = 0;
    while (state != 0 && n < 30) begin tick(); n++; end
    pin("unplug_to_idle", n, 7);
    pin("unplug_fault", fault, 0);
    resp_err = 0;

    // Unplug during CONFIG
    hpd = 1; resp_dly = 12;
    n = 0;
    while (!cfg_req && n < 100) begin tick(); n++; end
    hpd = 0;
    n = 0;
    while (state != 7 && n < 20) begin tick(); n++; end
    pin("drain_state", state, 7);
    pin("drain_req", cfg_req, 1);
    seen = 0; n = 0;
    while (state != 0 && n < 30) begin
      tick(); n++;
      if (run) seen = 1;
    end
    pin("drain_idle", state, 0);
    pin("drain_no_run", seen, 0);

    // GT loss in RUN
    hpd = 1; resp_dly = 3;
    n = 0;
    while (state != 4 && n < 100) begin tick(); n++; end
    pin("gt_run_att", attempt, 1);
    gt = 0; tick();
    pin("gt_loss_run", run, 0);
    pin("gt_loss_state", state, 2);
    gt = 1;
    n = 0;
    while (!cfg_req && n < 10) begin tick(); n++; end
    pin("gt_reconfig_att", attempt, 2);

    // Reset mid-CONFIG
    rst_n = 0; tick();
    pin("rst_cfg_req", cfg_req, 0);
    pin("rst_state", state, 0);
    pin("rst_attempt", attempt, 0);
    rst_n = 1;

    // Random traffic
    rand_err = 1; stray = 1;
    for (int c = 0; c < 6000; c++) begin
      if (hpd) begin
        if ($urandom_range(0, 89) == 0) hpd = 0;
      end else if ($urandom_range(0, 19) == 0) hpd = 1;
      if ($urandom_range(0, 59) == 0) gt = ~gt;
      rst_n = ($urandom_range(0, 999) != 0);
      resp_dly = $urandom_range(1, 6);
      tick();
    end
    rst_n = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
